// File: rtl/record_bank_serializer_pkg.sv
// Shared types and helpers for the record bank serializer.
package record_bank_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        SEALED,
        DRAINING
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } ser_state_t;

    localparam int unsigned DROP_COUNT_W = 16;

    function automatic int unsigned next_bank(input int unsigned idx, input int unsigned nbuf);
        return (idx + 1 == nbuf) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/record_bank_serializer_mem.sv
// Single record bank: synchronous write, show-ahead read with pop, fill count and empty flag.
module record_bank_mem
    import record_bank_pkg::*;
#(
    parameter int unsigned W     = 128,
    parameter int unsigned DEPTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   wr_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (wr_i) mem_q[wp_q] <= wdata_i;
    end

    always_comb begin
        wp_d  = wr_i  ? wp_q + 1'b1 : wp_q;
        rp_d  = pop_i ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q;
        case ({wr_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rp_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/record_bank_serializer.sv
// Multi-bank record buffer draining whole banks, LSB first, onto the omux byte lane.
// Optional partial-bank flush timeout: define RECORD_BANK_FLUSH_EN.
module record_bank_serializer
    import record_bank_pkg::*;
#(
    parameter int unsigned REC_BYTES    = 16,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned NBUF         = 4,
    parameter int unsigned OUT_BYTES    = 1,
    parameter int unsigned FLUSH_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [8*REC_BYTES-1:0]     rec_i,
    input  logic                       we_i,
    output logic                       omux_req_o,
    input  logic                       omux_sel_i,
    output logic [8*OUT_BYTES-1:0]     omux_data_o,
    output logic                       omux_last_o,
    output logic                       drop_o,
    output logic [DROP_COUNT_W-1:0]    drop_count_o,
    output logic [$clog2(NBUF+1)-1:0]  banks_ready_o
);
    localparam int unsigned RW     = 8 * REC_BYTES;
    localparam int unsigned LW     = 8 * OUT_BYTES;
    localparam int unsigned NBEATS = REC_BYTES / OUT_BYTES;
    localparam int unsigned BW     = $clog2(NBEATS) + 1;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam int unsigned PW     = $clog2(NBUF);
    localparam int unsigned KW     = $clog2(NBUF + 1);

    bank_state_t             bank_q [NBUF];
    bank_state_t             bank_d [NBUF];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    wr_act_q, wr_act_d;
    ser_state_t              ser_q, ser_d;
    logic [RW-1:0]           shreg_q, shreg_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    drop_q, drop_d;
    logic [DROP_COUNT_W-1:0] dcnt_q, dcnt_d;
    logic [KW-1:0]           ready_q, ready_d;

    logic [RW-1:0]           mem_rdata [NBUF];
    logic [CW-1:0]           mem_count [NBUF];
    logic                    mem_empty [NBUF];
    logic                    accept, seal, flush, pop;
    logic [PW-1:0]           nxt_wr;

    for (genvar g = 0; g < NBUF; g++) begin : g_bank
        record_bank_mem #(
            .W     (RW),
            .DEPTH (DEPTH)
        ) u_mem (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .wr_i    (accept && (wr_ptr_q == PW'(g))),
            .wdata_i (rec_i),
            .pop_i   (pop && (rd_ptr_q == PW'(g))),
            .rdata_o (mem_rdata[g]),
            .count_o (mem_count[g]),
            .empty_o (mem_empty[g])
        );
    end

`ifdef RECORD_BANK_FLUSH_EN
    localparam int unsigned IW = $clog2(FLUSH_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;

    // Counts idle cycles of a non-empty active bank; fires on the FLUSH_CYCLES-th one.
    always_comb begin
        flush  = 1'b0;
        idle_d = '0;
        if (wr_act_q && !accept && (mem_count[wr_ptr_q] != '0)) begin
            if (idle_q == IW'(FLUSH_CYCLES - 1)) flush = 1'b1;
            else                                 idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    // Timeout compiled out: FLUSH_CYCLES has no effect in this build.
    assign flush = 1'b0 && (FLUSH_CYCLES != 0);
`endif

    assign accept = we_i && wr_act_q;
    assign seal   = (accept && (mem_count[wr_ptr_q] == CW'(DEPTH - 1))) || flush;
    assign nxt_wr = PW'(next_bank(32'(wr_ptr_q), NBUF));
    assign pop    = (ser_q == LOAD);

    always_comb begin
        bank_d   = bank_q;
        wr_ptr_d = wr_ptr_q;
        wr_act_d = wr_act_q;
        rd_ptr_d = rd_ptr_q;
        ser_d    = ser_q;
        shreg_d  = shreg_q;
        beat_d   = beat_q;
        drop_d   = we_i && !wr_act_q;
        dcnt_d   = dcnt_q;
        ready_d  = '0;

        if (drop_d && (dcnt_q != '1)) dcnt_d = dcnt_q + 1'b1;

        for (int unsigned i = 0; i < NBUF; i++) begin
            if (bank_q[i] == SEALED || bank_q[i] == DRAINING) ready_d = ready_d + 1'b1;
        end

        unique case (ser_q)
            IDLE: begin
                if (bank_q[rd_ptr_q] == SEALED || bank_q[rd_ptr_q] == DRAINING) ser_d = LOAD;
            end
            LOAD: begin
                shreg_d          = mem_rdata[rd_ptr_q];
                beat_d           = '0;
                bank_d[rd_ptr_q] = DRAINING;
                ser_d            = SHIFT;
            end
            SHIFT: begin
                if (omux_sel_i) begin
                    shreg_d = shreg_q >> LW;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == BW'(NBEATS - 1)) begin
                        if (mem_empty[rd_ptr_q]) begin
                            bank_d[rd_ptr_q] = FREE;
                            rd_ptr_d         = PW'(next_bank(32'(rd_ptr_q), NBUF));
                            ser_d            = IDLE;
                        end else begin
                            ser_d = LOAD;
                        end
                    end
                end
            end
            default: ser_d = IDLE;
        endcase

        // Write side reads bank_d so a drain completing this edge frees the next bank in time.
        if (accept) bank_d[wr_ptr_q] = FILLING;
        if (seal) begin
            bank_d[wr_ptr_q] = SEALED;
            wr_ptr_d         = nxt_wr;
            wr_act_d         = (bank_d[nxt_wr] == FREE);
        end else if (!wr_act_q && (bank_q[wr_ptr_q] == FREE)) begin
            wr_act_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NBUF; i++) bank_q[i] <= FREE;
            wr_ptr_q <= '0;
            wr_act_q <= 1'b1;
            rd_ptr_q <= '0;
            ser_q    <= IDLE;
            shreg_q  <= '0;
            beat_q   <= '0;
            drop_q   <= 1'b0;
            dcnt_q   <= '0;
            ready_q  <= '0;
        end else begin
            bank_q   <= bank_d;
            wr_ptr_q <= wr_ptr_d;
            wr_act_q <= wr_act_d;
            rd_ptr_q <= rd_ptr_d;
            ser_q    <= ser_d;
            shreg_q  <= shreg_d;
            beat_q   <= beat_d;
            drop_q   <= drop_d;
            dcnt_q   <= dcnt_d;
            ready_q  <= ready_d;
        end
    end

    assign omux_req_o    = (ser_q == SHIFT);
    assign omux_last_o   = omux_req_o && (beat_q == BW'(NBEATS - 1));
    assign omux_data_o   = (omux_req_o && omux_sel_i) ? shreg_q[LW-1:0] : '0;
    assign drop_o        = drop_q;
    assign drop_count_o  = dcnt_q;
    assign banks_ready_o = ready_q;

endmodule

// File: tb/tb_record_bank_serializer.sv
// Scoreboard bench for record_bank_serializer: three configurations, queued expectations, negedge monitors.
module tb_record_bank_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];

    logic rst_n;

    // A: REC=4 OUT=1 DEPTH=2 NBUF=2
    logic [31:0] a_rec;
    logic        a_we, a_sel, a_req, a_last, a_drop;
    logic [7:0]  a_data;
    logic [15:0] a_dcnt;
    logic [1:0]  a_rdy;

    // B: REC=4 OUT=2 DEPTH=2 NBUF=2
    logic [31:0] b_rec;
    logic        b_we, b_sel, b_req, b_last, b_drop;
    logic [15:0] b_data;
    logic [15:0] b_dcnt;
    logic [1:0]  b_rdy;

    // C: REC=4 OUT=1 DEPTH=4 NBUF=2 FLUSH_CYCLES=8
    logic [31:0] c_rec;
    logic        c_we, c_sel, c_req, c_last, c_drop;
    logic [7:0]  c_data;
    logic [15:0] c_dcnt;
    logic [1:0]  c_rdy;

    record_bank_serializer #(.REC_BYTES(4), .DEPTH(2), .NBUF(2), .OUT_BYTES(1), .FLUSH_CYCLES(8)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .rec_i(a_rec), .we_i(a_we),
        .omux_req_o(a_req), .omux_sel_i(a_sel), .omux_data_o(a_data), .omux_last_o(a_last),
        .drop_o(a_drop), .drop_count_o(a_dcnt), .banks_ready_o(a_rdy)
    );

    record_bank_serializer #(.REC_BYTES(4), .DEPTH(2), .NBUF(2), .OUT_BYTES(2), .FLUSH_CYCLES(8)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .rec_i(b_rec), .we_i(b_we),
        .omux_req_o(b_req), .omux_sel_i(b_sel), .omux_data_o(b_data), .omux_last_o(b_last),
        .drop_o(b_drop), .drop_count_o(b_dcnt), .banks_ready_o(b_rdy)
    );

    record_bank_serializer #(.REC_BYTES(4), .DEPTH(4), .NBUF(2), .OUT_BYTES(1), .FLUSH_CYCLES(8)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .rec_i(c_rec), .we_i(c_we),
        .omux_req_o(c_req), .omux_sel_i(c_sel), .omux_data_o(c_data), .omux_last_o(c_last),
        .drop_o(c_drop), .drop_count_o(c_dcnt), .banks_ready_o(c_rdy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input logic [7:0] d, input logic l);
        qa.push_back('{data: 16'(d), last: l});
    endtask

    task automatic exp_b(input logic [15:0] d, input logic l);
        qb.push_back('{data: d, last: l});
    endtask

    // Byte-lane split of a record, least-significant byte first.
    task automatic exp_rec_a(input logic [31:0] r);
        for (int i = 0; i < 4; i++) exp_a(r[8*i +: 8], i == 3);
    endtask

    task automatic exp_rec_c(input logic [31:0] r);
        for (int i = 0; i < 4; i++) qc.push_back('{data: 16'(r[8*i +: 8]), last: (i == 3)});
    endtask

    task automatic wr_a(input logic [31:0] r);
        a_rec = r; a_we = 1'b1; tick(); a_we = 1'b0;
    endtask

    task automatic wr_b(input logic [31:0] r);
        b_rec = r; b_we = 1'b1; tick(); b_we = 1'b0;
    endtask

    task automatic wr_c(input logic [31:0] r);
        c_rec = r; c_we = 1'b1; tick(); c_we = 1'b0;
    endtask

    task automatic drain_a(input int maxc);
        int n = 0;
        while (qa.size() != 0 && n < maxc) begin tick(); n++; end
        check("A drained", qa.size(), 0);
    endtask

    task automatic drain_b(input int maxc);
        int n = 0;
        while (qb.size() != 0 && n < maxc) begin tick(); n++; end
        check("B drained", qb.size(), 0);
    endtask

    task automatic drain_c(input int maxc);
        int n = 0;
        while (qc.size() != 0 && n < maxc) begin tick(); n++; end
        check("C drained", qc.size(), 0);
    endtask

    // Monitors: pop on each granted beat; data must be 0 without grant; a gap after every last beat.
    logic a_gap = 1'b0, b_gap = 1'b0, c_gap = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (a_gap) check("A gap after record", a_req, 0);
            a_gap = a_req && a_sel && a_last;
            if (!a_sel) check("A data without grant", a_data, 0);
            if (a_req && a_sel) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL A unexpected beat: got %h want none", a_data);
                end else begin
                    e = qa.pop_front();
                    check("A beat data", a_data, e.data);
                    check("A beat last", a_last, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (b_gap) check("B gap after record", b_req, 0);
            b_gap = b_req && b_sel && b_last;
            if (b_req && b_sel) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL B unexpected beat: got %h want none", b_data);
                end else begin
                    e = qb.pop_front();
                    check("B beat data", b_data, e.data);
                    check("B beat last", b_last, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (c_gap) check("C gap after record", c_req, 0);
            c_gap = c_req && c_sel && c_last;
            if (c_req && c_sel) begin
                if (qc.size() == 0) begin
                    total++; bad++;
                    $display("FAIL C unexpected beat: got %h want none", c_data);
                end else begin
                    e = qc.pop_front();
                    check("C beat data", c_data, e.data);
                    check("C beat last", c_last, e.last);
                end
            end
        end
    end

    initial begin
        logic [15:0] pat;
        rst_n = 1'b0;
        a_rec = '0; a_we = 1'b0; a_sel = 1'b0;
        b_rec = '0; b_we = 1'b0; b_sel = 1'b0;
        c_rec = '0; c_we = 1'b0; c_sel = 1'b0;
        repeat (3) tick();

        check("rst A req",  a_req,  0);
        check("rst A last", a_last, 0);
        check("rst A data", a_data, 0);
        check("rst A drop", a_drop, 0);
        check("rst A dcnt", a_dcnt, 0);
        check("rst A rdy",  a_rdy,  0);
        check("rst B req",  b_req,  0);
        check("rst C req",  c_req,  0);
        rst_n = 1'b1;
        tick();

        // Test 1: two records, one bank, byte lane, sel held high
        a_sel = 1'b1;
        exp_a(8'hAA, 0); exp_a(8'hBB, 0); exp_a(8'hCC, 0); exp_a(8'hDD, 1);
        exp_a(8'h11, 0); exp_a(8'h22, 0); exp_a(8'h33, 0); exp_a(8'h44, 1);
        wr_a(32'hDDCCBBAA);
        wr_a(32'h44332211);
        check("T1 req at seal+0", a_req, 0);
        tick();
        check("T1 req at seal+1", a_req, 0);
        tick();
        check("T1 req at seal+2", a_req, 1);
        drain_a(50);
        repeat (3) tick();
        check("T1 banks_ready after drain", a_rdy, 0);

        // Test 2: 16-bit lane
        b_sel = 1'b1;
        exp_b(16'h4321, 0); exp_b(16'h8765, 1);
        exp_b(16'hCBA9, 0); exp_b(16'h0FED, 1);
        wr_b(32'h87654321);
        wr_b(32'h0FEDCBA9);
        drain_b(50);

        // Test 3: both banks full, fifth write dropped
        a_sel = 1'b0;
        wr_a(32'h03020100);
        wr_a(32'h13121110);
        wr_a(32'h23222120);
        wr_a(32'h33323130);
        wr_a(32'h43424140);
        check("T3 drop pulse", a_drop, 1);
        check("T3 drop count", a_dcnt, 1);
        tick();
        check("T3 drop pulse end", a_drop, 0);
        tick();
        check("T3 banks_ready full", a_rdy, 2);
        exp_rec_a(32'h03020100);
        exp_rec_a(32'h13121110);
        exp_rec_a(32'h23222120);
        exp_rec_a(32'h33323130);
        a_sel = 1'b1;
        drain_a(100);
        repeat (6) tick();
        check("T3 no fifth record", a_rdy, 0);
        check("T3 drop count held", a_dcnt, 1);

        // Test 4: grant toggling mid-record
        a_sel = 1'b0;
        exp_rec_a(32'h5A6B7C8D);
        exp_rec_a(32'hE1F20314);
        wr_a(32'h5A6B7C8D);
        wr_a(32'hE1F20314);
        pat = 16'b1011_0010_0110_1001;
        for (int i = 0; i < 40; i++) begin
            a_sel = pat[i % 16];
            tick();
        end
        a_sel = 1'b1;
        drain_a(50);
        repeat (3) tick();

        // Test 5: single record into DEPTH=4 bank, then idle
        c_sel = 1'b1;
`ifdef RECORD_BANK_FLUSH_EN
        exp_rec_c(32'hC3B2A190);
        wr_c(32'hC3B2A190);
        repeat (9) tick();
        check("T5 req before flush", c_req, 0);
        tick();
        check("T5 req after flush", c_req, 1);
        drain_c(30);
`else
        wr_c(32'hC3B2A190);
        repeat (100) tick();
        check("T5 partial bank held", c_req, 0);
        check("T5 no sealed bank", c_rdy, 0);
        drain_c(1);
`endif

        // Test 6: reset while a record is shifting
        a_sel = 1'b0;
        wr_a(32'h99887766);
        wr_a(32'h55443322);
        wr_a(32'h11111111);
        wr_a(32'h22222222);
        wr_a(32'h33333333);
        tick();
        check("T6 in shift", a_req, 1);
        check("T6 drops before reset", a_dcnt, 2);
        rst_n = 1'b0;
        tick();
        check("T6 req after reset", a_req, 0);
        check("T6 rdy after reset", a_rdy, 0);
        check("T6 dcnt after reset", a_dcnt, 0);
        qb.delete();
        qc.delete();
        rst_n = 1'b1;
        tick();
        a_sel = 1'b1;
        exp_a(8'hAA, 0); exp_a(8'hBB, 0); exp_a(8'hCC, 0); exp_a(8'hDD, 1);
        exp_a(8'h11, 0); exp_a(8'h22, 0); exp_a(8'h33, 0); exp_a(8'h44, 1);
        wr_a(32'hDDCCBBAA);
        wr_a(32'h44332211);
        check("T6 req at seal+0", a_req, 0);
        tick();
        check("T6 req at seal+1", a_req, 0);
        tick();
        check("T6 req at seal+2", a_req, 1);
        drain_a(50);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
